spi_target: RTL and testbench
=============================

# spi_target

SPI mode-0 target (peripheral side): receives bytes clocked in by an external SPI controller and returns bytes on MISO, all in the system `clk` domain. SCK, MOSI and SS_n are oversampled through synchronizers, so the block needs no SCK clock domain. It sits beside the register file. The CPU writes reply bytes into a transmit holding register and pops received bytes from a receive buffer.

## Interface
Parameters:
- `SYNC_STAGES`, 2: synchronizer depth on SCK/MOSI/SS_n (≥2).

Ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous, active-low reset
- `spi_sck`  in  1  SPI clock from controller (idle low)
- `spi_ss_n`  in  1  target select, active low
- `spi_mosi`  in  1  controller-to-target data
- `spi_miso`  out  1  target-to-controller data, MSB first
- `spi_miso_oe`  out  1  MISO output enable (= synchronized select)
- `txdata`  in  8  next reply byte
- `txload`  in  1  one-cycle strobe: capture `txdata` into holding register
- `txempty`  out  1  holding register free
- `rxdata`  out  8  oldest received byte
- `rxvalid`  out  1  `rxdata` valid
- `rxread`  in  1  one-cycle strobe: pop `rxdata`
- `active`  out  1  synchronized select asserted
- `overrun`  out  1  sticky: received byte dropped
- `underrun`  out  1  sticky: byte started with empty holding register
- `clrflags`  in  1  clear `overrun` and `underrun`

## Operation
- Sync reset values: sck 0, mosi 0, ss_n 1. One extra "previous" register per line gives rise and fall detection on SCK and SS_n.
- Select fall:
  - `active` goes to 1 and the bit counter goes to 0.
  - The TX shift register loads the holding register and `txempty` goes to 1.
  - If the holding register was empty, the shift register loads 8'hFF and `underrun` is set.
- SCK rise, while active: shift the synchronized MOSI into the RX shift register and increment the bit counter (3 bits, wraps 7→0).
- Byte complete: on the rise that wraps the counter, push the assembled byte into the RX buffer.
- SCK fall, while active:
  - Counter ≠ 0: shift the TX shift register left.
  - Counter = 0 (byte boundary): reload the TX shift register from the holding register, with the same empty/0xFF/`underrun` rule as select fall.
- Outputs: `spi_miso` = TX shift register bit 7 AND `active`. `spi_miso_oe` = `active`.
- Select rise (deassert) mid-byte: discard partial RX bits, clear the counter, drop `active`. No push and no `overrun`. The holding register is untouched.
- SCK edges while deselected are ignored.
- `txload`:
  - When `txempty`=1: capture the byte and clear `txempty`.
  - When `txempty`=0: ignored, the held byte is kept.
  - When it coincides with a reload: the reload takes the old content and sets `txempty`, and `txload` is then ignored.
- RX buffer (single holding register by default):
  - Push while full without `rxread`: new byte dropped, old byte kept, `overrun` set.
  - Push and `rxread` in the same cycle while full: pop then push, no overrun.
- `clrflags` loses to a same-cycle set (the flag stays 1).
- Reset values: `spi_miso` 0, `spi_miso_oe` 0, `active` 0, `txempty` 1, `rxvalid` 0, `rxdata` 0, `overrun` 0, `underrun` 0. Shift registers and counter are 0.

## Timing
- Let k be the first `clk` edge that samples a pin change. With `SYNC_STAGES`=2, the edge is acted on at clk edge k+2:
  - a push makes `rxvalid`/`rxdata` valid after edge k+2;
  - MISO changes after edge k+2.
- SCK high and low phases must each be ≥4 `clk` periods (f_SCK ≤ f_clk/8).
- SS_n fall to first SCK rise must be ≥4 `clk` periods.
- `txempty` rises after the same edge that performs the reload.
- `rxvalid` falls the cycle after `rxread`, unless a same-cycle push or (FIFO) remaining entries keep it high.

## Configuration
- `SPI_TARGET_RXFIFO_EN` defined: the RX buffer is a 4-entry FIFO.
  - `overrun` is set only on a push while 4 entries are held.
  - `rxdata` always shows the oldest entry.
  - `rxvalid` = FIFO not empty.
- Not defined: single holding register as described above.

## Structure
- Shared package `spi_pkg`:
  - `SPI_FILL_BYTE` = 8'hFF;
  - `SPI_RXFIFO_DEPTH` = 4;
  - bit-counter width constant.
- Sub-module `spi_sync`: `SYNC_STAGES`-deep synchronizer with a parameterized reset value. It is instantiated three times.
- The FIFO is inline under the macro.

## Test plan
- Reset then idle: all outputs at reset values; SCK toggling with SS_n high → no `rxvalid`, counter stays 0.
- Load 8'hA5, select, controller sends 8'h3C at clk/8 → controller reads 8'hA5 on MISO; `rxdata`=8'h3C, `rxvalid` 1 at k+2 after the 8th rise; `txempty`=1.
- Two-byte burst, only 8'h11 preloaded → second reply is 8'hFF and `underrun`=1. `clrflags` clears it.
- Send 8'h01 then 8'h02 without `rxread` → `rxdata` stays 8'h01, `overrun`=1. With the macro: 5 bytes needed to set `overrun`, and reads return 01,02,03,04.
- SS_n deasserted after 5 bits, then a full byte 8'hC3 → only 8'hC3 is received, no overrun.
- `rxread` in the same cycle as a push while full → no overrun, next `rxdata` is the new byte.

Source files
------------

// File: rtl/spi_pkg.sv
// spi_pkg: shared constants for the SPI target
package spi_pkg;
  localparam logic [7:0] SPI_FILL_BYTE = 8'hFF;
  localparam int SPI_RXFIFO_DEPTH = 4;
  localparam int SPI_PTR_W = $clog2(SPI_RXFIFO_DEPTH);
  localparam int SPI_CNT_W = 3;
endpackage

// File: rtl/spi_sync.sv
// spi_sync: multi-stage synchronizer with configurable reset value
module spi_sync #(
  parameter int STAGES = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] sync_q, sync_d;
  // shift the pin value through the chain
  always_comb sync_d = {sync_q[STAGES-2:0], d};
  // synchronizer flops
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync_q <= {STAGES{RST_VAL}};
    else sync_q <= sync_d;
  assign q = sync_q[STAGES-1];
endmodule

// File: rtl/spi_target.sv
// spi_target: oversampled SPI mode-0 target; define SPI_TARGET_RXFIFO_EN for a 4-entry RX FIFO
module spi_target
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       spi_sck,
  input  logic       spi_ss_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  input  logic [7:0] txdata,
  input  logic       txload,
  output logic       txempty,
  output logic [7:0] rxdata,
  output logic       rxvalid,
  input  logic       rxread,
  output logic       active,
  output logic       overrun,
  output logic       underrun,
  input  logic       clrflags
);
  logic sck_s, mosi_s, ss_n_s;
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck (.clk(clk), .rst_n(rst_n), .d(spi_sck), .q(sck_s));
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (.clk(clk), .rst_n(rst_n), .d(spi_mosi), .q(mosi_s));
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss (.clk(clk), .rst_n(rst_n), .d(spi_ss_n), .q(ss_n_s));
  logic sck_prev_q, ss_prev_q, active_q, active_d, txempty_q, txempty_d;
  logic overrun_q, overrun_d, underrun_q, underrun_d;
  logic [SPI_CNT_W-1:0] cnt_q, cnt_d;
  logic [6:0] rx_sh_q, rx_sh_d;
  logic [7:0] tx_sh_q, tx_sh_d, hold_q, hold_d, rx_byte;
  logic live, sck_rise, sck_fall, reload, push, ovf;
`ifdef SPI_TARGET_RXFIFO_EN
  logic [7:0] mem_q [SPI_RXFIFO_DEPTH];
  logic [7:0] mem_d [SPI_RXFIFO_DEPTH];
  logic [SPI_PTR_W-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [SPI_PTR_W:0] fill_q, fill_d;
  logic pop, full, acc;
`else
  logic [7:0] rxdata_q, rxdata_d;
  logic rxvalid_q, rxvalid_d;
`endif
  // edge detection, shift/count datapath, TX holding handshake and RX buffering
  always_comb begin
    live = active_q & ~ss_n_s;
    sck_rise = live & sck_s & ~sck_prev_q;
    sck_fall = live & ~sck_s & sck_prev_q;
    reload = (ss_prev_q & ~ss_n_s) | (sck_fall & (cnt_q == '0));
    push = sck_rise & (cnt_q == '1);
    rx_byte = {rx_sh_q, mosi_s};
    active_d = ~ss_n_s;
    cnt_d = live ? cnt_q + SPI_CNT_W'(sck_rise) : '0;
    rx_sh_d = live ? (sck_rise ? rx_byte[6:0] : rx_sh_q) : '0;
    tx_sh_d = reload ? (txempty_q ? SPI_FILL_BYTE : hold_q) : sck_fall ? {tx_sh_q[6:0], 1'b0} : tx_sh_q;
    hold_d = (txload & txempty_q & ~reload) ? txdata : hold_q;
    txempty_d = reload | (txempty_q & ~txload);
`ifdef SPI_TARGET_RXFIFO_EN
    pop = rxread & (fill_q != '0);
    full = fill_q == (SPI_PTR_W+1)'(SPI_RXFIFO_DEPTH);
    acc = push & (~full | pop);
    ovf = push & full & ~pop;
    mem_d = mem_q;
    if (acc) mem_d[wr_q] = rx_byte;
    wr_d = wr_q + SPI_PTR_W'(acc);
    rd_d = rd_q + SPI_PTR_W'(pop);
    fill_d = fill_q + (SPI_PTR_W+1)'(acc) - (SPI_PTR_W+1)'(pop);
`else
    rxdata_d = (push & (~rxvalid_q | rxread)) ? rx_byte : rxdata_q;
    rxvalid_d = push | (rxvalid_q & ~rxread);
    ovf = push & rxvalid_q & ~rxread;
`endif
    overrun_d = ovf | (overrun_q & ~clrflags);
    underrun_d = (reload & txempty_q) | (underrun_q & ~clrflags);
  end
  // state registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sck_prev_q <= 1'b0;
      ss_prev_q <= 1'b1;
      active_q <= 1'b0;
      cnt_q <= '0;
      rx_sh_q <= '0;
      tx_sh_q <= '0;
      hold_q <= '0;
      txempty_q <= 1'b1;
      overrun_q <= 1'b0;
      underrun_q <= 1'b0;
`ifdef SPI_TARGET_RXFIFO_EN
      mem_q <= '{default: '0};
      rd_q <= '0;
      wr_q <= '0;
      fill_q <= '0;
`else
      rxdata_q <= '0;
      rxvalid_q <= 1'b0;
`endif
    end else begin
      sck_prev_q <= sck_s;
      ss_prev_q <= ss_n_s;
      active_q <= active_d;
      cnt_q <= cnt_d;
      rx_sh_q <= rx_sh_d;
      tx_sh_q <= tx_sh_d;
      hold_q <= hold_d;
      txempty_q <= txempty_d;
      overrun_q <= overrun_d;
      underrun_q <= underrun_d;
`ifdef SPI_TARGET_RXFIFO_EN
      mem_q <= mem_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
      fill_q <= fill_d;
`else
      rxdata_q <= rxdata_d;
      rxvalid_q <= rxvalid_d;
`endif
    end
`ifdef SPI_TARGET_RXFIFO_EN
  assign rxdata = mem_q[rd_q];
  assign rxvalid = fill_q != '0;
`else
  assign rxdata = rxdata_q;
  assign rxvalid = rxvalid_q;
`endif
  assign spi_miso = tx_sh_q[7] & active_q;
  assign spi_miso_oe = active_q;
  assign active = active_q;
  assign txempty = txempty_q;
  assign overrun = overrun_q;
  assign underrun = underrun_q;
endmodule

// File: tb/tb_spi_target.sv
// tb_spi_target: randomized self-checking bench for spi_target against a byte-level model
module tb_spi_target;
`ifdef SPI_TARGET_RXFIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif
  logic clk = 1'b0, rst_n = 1'b0;
  logic spi_sck = 1'b0, spi_ss_n = 1'b1, spi_mosi = 1'b0;
  logic spi_miso, spi_miso_oe, txempty, rxvalid, active, overrun, underrun;
  logic [7:0] txdata = 8'h00, rxdata;
  logic txload = 1'b0, rxread = 1'b0, clrflags = 1'b0;
  int tests = 0, fails = 0;
  logic [7:0] m_hold, m_tx;
  bit m_full, m_ovr, m_und;
  logic [7:0] m_rx[$];

  spi_target #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .spi_sck(spi_sck), .spi_ss_n(spi_ss_n), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe), .txdata(txdata), .txload(txload),
    .txempty(txempty), .rxdata(rxdata), .rxvalid(rxvalid), .rxread(rxread), .active(active),
    .overrun(overrun), .underrun(underrun), .clrflags(clrflags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic void m_reload();
    m_tx = m_full ? m_hold : 8'hFF;
    if (!m_full) m_und = 1'b1;
    m_full = 1'b0;
  endfunction

  task automatic tx_load(input logic [7:0] v);
    @(negedge clk); txdata = v; txload = 1'b1;
    @(negedge clk); txload = 1'b0;
    if (!m_full) begin m_hold = v; m_full = 1'b1; end
  endtask

  task automatic clr();
    @(negedge clk); clrflags = 1'b1;
    @(negedge clk); clrflags = 1'b0;
    m_ovr = 1'b0; m_und = 1'b0;
  endtask

  task automatic rd();
    chk("rxvalid", rxvalid, 32'(m_rx.size() != 0));
    if (m_rx.size() != 0) begin
      chk("rxdata", rxdata, m_rx[0]);
      @(negedge clk); rxread = 1'b1;
      @(negedge clk); rxread = 1'b0;
      void'(m_rx.pop_front());
    end
  endtask

  task automatic drain();
    while (m_rx.size() != 0) rd();
  endtask

  task automatic sel();
    @(negedge clk); spi_ss_n = 1'b0;
    m_reload();
  endtask

  task automatic desel();
    wait_n(5); spi_ss_n = 1'b1; wait_n(6);
  endtask

  task automatic chk_state();
    chk("active", active, 0);
    chk("miso_oe", spi_miso_oe, 0);
    chk("miso", spi_miso, 0);
    chk("txempty", txempty, 32'(!m_full));
    chk("overrun", overrun, 32'(m_ovr));
    chk("underrun", underrun, 32'(m_und));
    chk("rxvalid_st", rxvalid, 32'(m_rx.size() != 0));
    if (m_rx.size() != 0) chk("rxdata_st", rxdata, m_rx[0]);
  endtask

  // mode 0: plain, 1: check push latency on the last rise, 2: rxread coincides with the push
  task automatic send_byte(input logic [7:0] v, input int nbits, input int mode, input bit ld, input logic [7:0] ldv);
    logic [7:0] got, exp;
    got = 8'h00;
    exp = m_tx;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = v[7-i];
      wait_n(5);
      got[7-i] = spi_miso;
      spi_sck = 1'b1;
      if (i == 7 && mode == 1) begin
        @(negedge clk); chk("rxv_k", rxvalid, 0);
        @(negedge clk); chk("rxv_k1", rxvalid, 0);
        @(negedge clk); chk("rxv_k2", rxvalid, 1); chk("rxd_k2", rxdata, v);
        wait_n(2);
      end else if (i == 7 && mode == 2) begin
        wait_n(2); rxread = 1'b1;
        @(negedge clk); rxread = 1'b0;
        void'(m_rx.pop_front());
        wait_n(2);
      end else if (i == 0 && ld) begin
        tx_load(ldv); wait_n(3);
      end else wait_n(5);
      spi_sck = 1'b0;
    end
    if (nbits == 8) begin
      chk("reply", got, exp);
      if (m_rx.size() < DEPTH) m_rx.push_back(v); else m_ovr = 1'b1;
      m_reload();
    end
  endtask

  initial begin
    logic [7:0] r;
    int len;
    m_full = 1'b0; m_ovr = 1'b0; m_und = 1'b0; m_hold = 8'h00; m_tx = 8'h00;
    wait_n(3);
    chk("rst_miso", spi_miso, 0);
    chk("rst_oe", spi_miso_oe, 0);
    chk("rst_active", active, 0);
    chk("rst_txempty", txempty, 1);
    chk("rst_rxvalid", rxvalid, 0);
    chk("rst_rxdata", rxdata, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_underrun", underrun, 0);
    rst_n = 1'b1;
    wait_n(2);
    for (int i = 0; i < 8; i++) begin
      spi_mosi = i[0]; spi_sck = 1'b1; wait_n(4); spi_sck = 1'b0; wait_n(4);
    end
    chk("idle_rxvalid", rxvalid, 0);
    chk("idle_active", active, 0);
    chk("idle_txempty", txempty, 1);
    // basic transfer
    tx_load(8'hA5);
    chk("load_txempty", txempty, 0);
    sel();
    send_byte(8'h3C, 8, 1, 1'b0, 8'h00);
    desel();
    chk_state();
    chk("a5_rx", rxdata, 8'h3C);
    rd();
    // underrun on the second byte of a burst
    clr();
    tx_load(8'h11);
    sel();
    send_byte(8'h5A, 8, 0, 1'b0, 8'h00);
    rd();
    send_byte(8'h6B, 8, 0, 1'b0, 8'h00);
    desel();
    chk_state();
    chk("und_set", underrun, 1);
    clr();
    chk("und_clr", underrun, 0);
    drain();
    // overrun once the buffer is full
    for (int i = 1; i <= DEPTH + 1; i++) begin
      sel(); send_byte(8'(i), 8, 0, 1'b0, 8'h00); desel();
    end
    chk_state();
    chk("ovr_set", overrun, 1);
    chk("ovr_oldest", rxdata, 8'h01);
    drain();
    clr();
    // aborted partial byte is discarded
    sel(); send_byte(8'hF0, 5, 0, 1'b0, 8'h00); desel();
    chk_state();
    sel(); send_byte(8'hC3, 8, 0, 1'b0, 8'h00); desel();
    chk_state();
    chk("abort_rx", rxdata, 8'hC3);
    chk("abort_ovr", overrun, 0);
    drain();
    // pop and push in the same cycle
    sel();
    send_byte(8'h55, 8, 0, 1'b0, 8'h00);
    send_byte(8'hAA, 8, 2, 1'b0, 8'h00);
    desel();
    chk_state();
    chk("pp_ovr", overrun, 0);
    chk("pp_rx", rxdata, 8'hAA);
    drain();
    clr();
    // randomized bursts
    for (int b = 0; b < 25; b++) begin
      if ($urandom_range(1, 0) == 1) tx_load(8'($urandom));
      sel();
      len = $urandom_range(3, 1);
      for (int j = 0; j < len; j++) begin
        r = 8'($urandom);
        send_byte(r, 8, 0, 1'($urandom_range(1, 0)), 8'($urandom));
        if ($urandom_range(2, 0) == 0) rd();
      end
      if ($urandom_range(5, 0) == 0) send_byte(8'($urandom), $urandom_range(7, 1), 0, 1'b0, 8'h00);
      desel();
      chk_state();
      if ($urandom_range(2, 0) == 0) clr();
      for (int j = $urandom_range(2, 0); j > 0; j--) rd();
    end
    drain();
    chk_state();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
